uart_frame_ctrl: RTL

Frame controller that sequences the byte stream from the UART receiver into a 81-cell Sudoku grid load. It hunts for a start-of-frame byte, validates and writes each cell into board storage, checks a trailing XOR checksum, and holds host flow control until the solver consumes the grid. It sits between the UART receiver (`byte_ready`/`uart_byte`) and the board RAM/solver.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_idle_timer.sv | 39 +++
 rtl/uart_frame_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART Sudoku frame loader.
package uart_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2,
    S_HOLD = 2'd3
  } frame_state_t;

  // Abort causes reported on err_code
  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_BAD_DIGIT = 2'b01,
    ERR_CSUM      = 2'b10,
    ERR_TIMEOUT   = 2'b11
  } err_code_t;

  localparam int         CELL_COUNT = 81;
  localparam logic [7:0] MAX_DIGIT  = 8'd9;
  localparam logic [6:0] LAST_CELL  = 7'(CELL_COUNT - 1);

  // A data byte is a legal cell value when it encodes 0..9
  function automatic logic is_digit(input logic [7:0] b);
    return (b <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter. Only built when UART_FRAME_TIMEOUT_EN is defined.
// expire flags the LIMIT-th consecutive enabled cycle without a clear.
module uart_idle_timer #(
  parameter logic [15:0] LIMIT = 16'd40000
) (
  input  logic uart_sampling_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  // count_reg holds how many idle cycles preceded the current one
  logic [15:0] count_reg;
  logic [15:0] count_next;

  // Clear has priority; counting pauses while disabled
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A byte in the same cycle (clr) suppresses expiry: the byte wins
  assign expire = en && !clr && (count_reg == LIMIT - 16'd1);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Sequences UART bytes into an 81-cell Sudoku grid load:
// SOF hunt, 81 digit cells written to board RAM, trailing XOR checksum,
// then host flow control held until the solver takes the grid.
// Optional build macro: UART_FRAME_TIMEOUT_EN enables the inter-byte
// idle timeout (err_code 11) using TIMEOUT_CYCLES.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic       uart_sampling_clk,
  input  logic       rst,
  input  logic       byte_ready,
  input  logic [7:0] uart_byte,
  input  logic       grid_consumed,
  output logic       rx_hold,
  output logic       cell_we,
  output logic [6:0] cell_addr,
  output logic [3:0] cell_val,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  frame_state_t state_reg, state_next;
  logic [6:0]   idx_reg, idx_next;
  logic [7:0]   csum_reg, csum_next;
  logic         timeout_expired;

  logic         rx_hold_reg, rx_hold_next;
  logic         cell_we_reg, cell_we_next;
  logic [6:0]   cell_addr_reg, cell_addr_next;
  logic [3:0]   cell_val_reg, cell_val_next;
  logic         frame_done_reg, frame_done_next;
  logic         frame_err_reg, frame_err_next;
  err_code_t    err_code_reg, err_code_next;
  logic         overrun_reg, overrun_next;

`ifdef UART_FRAME_TIMEOUT_EN
  logic timer_en;
  logic timer_clr;

  // Idle time only matters while a frame is in flight; every byte
  // (including the SOF that enters S_DATA) restarts the count
  assign timer_en  = (state_reg == S_DATA) || (state_reg == S_CSUM);
  assign timer_clr = byte_ready;

  uart_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .uart_sampling_clk(uart_sampling_clk),
    .rst              (rst),
    .en               (timer_en),
    .clr              (timer_clr),
    .expire           (timeout_expired)
  );
`else
  // No counter in this build; the limit parameter is kept only so the
  // port/parameter list is identical across builds
  logic [15:0] timeout_cfg_unused;
  assign timeout_cfg_unused = TIMEOUT_CYCLES;
  assign timeout_expired    = 1'b0;
`endif

  // State, cell index and running checksum registers
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_HUNT;
      idx_reg   <= '0;
      csum_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      csum_reg  <= csum_next;
    end
  end

  // Next-state: frame sequencing plus index/checksum bookkeeping
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    case (state_reg)
      S_HUNT: begin
        if (byte_ready && (uart_byte == SOF_BYTE)) begin
          state_next = S_DATA;
          idx_next   = '0;
          csum_next  = '0;
        end
      end
      S_DATA: begin
        if (byte_ready) begin
          if (!is_digit(uart_byte)) begin
            state_next = S_HUNT;
          end else begin
            idx_next  = idx_reg + 7'd1;
            csum_next = csum_reg ^ uart_byte;
            if (idx_reg == LAST_CELL) begin
              state_next = S_CSUM;
            end
          end
        end else if (timeout_expired) begin
          state_next = S_HUNT;
        end
      end
      S_CSUM: begin
        if (byte_ready) begin
          state_next = (uart_byte == csum_reg) ? S_HOLD : S_HUNT;
        end else if (timeout_expired) begin
          state_next = S_HUNT;
        end
      end
      S_HOLD: begin
        if (grid_consumed) begin
          state_next = S_HUNT;
        end
      end
      default: state_next = S_HUNT;
    endcase
  end

  // Output decode: next values for the registered outputs
  always_comb begin
    cell_we_next    = 1'b0;
    cell_addr_next  = cell_addr_reg;
    cell_val_next   = cell_val_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    err_code_next   = err_code_reg;
    overrun_next    = overrun_reg;
    rx_hold_next    = (state_next == S_HOLD);
    case (state_reg)
      S_DATA: begin
        if (byte_ready) begin
          if (is_digit(uart_byte)) begin
            cell_we_next   = 1'b1;
            cell_addr_next = idx_reg;
            cell_val_next  = uart_byte[3:0];
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_BAD_DIGIT;
          end
        end else if (timeout_expired) begin
          frame_err_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
        end
      end
      S_CSUM: begin
        if (byte_ready) begin
          if (uart_byte == csum_reg) begin
            frame_done_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_CSUM;
          end
        end else if (timeout_expired) begin
          frame_err_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
        end
      end
      S_HOLD: begin
        if (byte_ready) begin
          overrun_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      rx_hold_reg    <= 1'b0;
      cell_we_reg    <= 1'b0;
      cell_addr_reg  <= '0;
      cell_val_reg   <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_code_reg   <= ERR_NONE;
      overrun_reg    <= 1'b0;
    end else begin
      rx_hold_reg    <= rx_hold_next;
      cell_we_reg    <= cell_we_next;
      cell_addr_reg  <= cell_addr_next;
      cell_val_reg   <= cell_val_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      err_code_reg   <= err_code_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign rx_hold    = rx_hold_reg;
  assign cell_we    = cell_we_reg;
  assign cell_addr  = cell_addr_reg;
  assign cell_val   = cell_val_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign overrun    = overrun_reg;

endmodule
